// File: rtl/mips_pkg.sv
// Shared register-file constants and helpers for the CPU write-side blocks.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Register 0 is hardwired to zero, so it never shows up as a pending destination.
   function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
      logic [REG_COUNT-1:0] v;
      v = '0;
      if (r != REG_ZERO) begin
         v[r] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// In-order tracker of outstanding loads; bus returns fill the oldest entry still awaiting data.
module load_return_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_alloc,
   input  logic [ADDR_W-1:0]            i_alloc_reg,
   input  logic                         i_rvalid,
   input  logic [DATA_W-1:0]            i_rdata,
   input  logic                         i_pop,
   output logic [ADDR_W-1:0]            o_head_reg,
   output logic [DATA_W-1:0]            o_head_data,
   output logic                         o_head_has_data,
   output logic [DEPTH-1:0]             o_occupied,
   output logic [DEPTH-1:0][ADDR_W-1:0] o_entry_reg,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_fill_miss
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][ADDR_W-1:0] r_reg;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [DEPTH-1:0]             r_occ;
   logic [DEPTH-1:0]             r_have;
   logic [PTR_W-1:0]             r_head;
   logic [PTR_W-1:0]             r_tail;
   logic [PTR_W-1:0]             r_fill;
   logic [CNT_W-1:0]             r_count;

   logic w_alloc;
   logic w_fill_hit;

   assign o_full          = (r_count == CNT_W'(DEPTH));
   assign o_empty         = (r_count == '0);
   assign w_alloc         = i_alloc & ~o_full;
   assign w_fill_hit      = i_rvalid & r_occ[r_fill] & ~r_have[r_fill];
   assign o_fill_miss     = i_rvalid & ~w_fill_hit;
   assign o_head_reg      = r_reg[r_head];
   assign o_head_data     = r_data[r_head];
   assign o_head_has_data = r_occ[r_head] & r_have[r_head];
   assign o_occupied      = r_occ;
   assign o_entry_reg     = r_reg;

   // Alloc, fill and pop always land on distinct entries, so their updates never collide.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_reg   <= '0;
         r_data  <= '0;
         r_occ   <= '0;
         r_have  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_fill  <= '0;
         r_count <= '0;
      end else begin
         if (w_alloc) begin
            r_reg[r_tail]  <= i_alloc_reg;
            r_occ[r_tail]  <= 1'b1;
            r_have[r_tail] <= 1'b0;
            r_tail         <= r_tail + PTR_W'(1);
         end
         if (w_fill_hit) begin
            r_data[r_fill] <= i_rdata;
            r_have[r_fill] <= 1'b1;
            r_fill         <= r_fill + PTR_W'(1);
         end
         if (i_pop) begin
            r_occ[r_head]  <= 1'b0;
            r_have[r_head] <= 1'b0;
            r_head         <= r_head + PTR_W'(1);
         end
         case ({w_alloc, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU results and in-order load returns onto the single register-file write port.
module regfile_write_arbiter
   import mips_pkg::*;
#(
   parameter int LOAD_DEPTH = 2,
   parameter int DATA_W     = REG_DATA_W,
   parameter int ADDR_W     = REG_ADDR_W
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_clk_enable,
   input  logic                 i_alu_valid,
   input  logic [ADDR_W-1:0]    i_alu_reg,
   input  logic [DATA_W-1:0]    i_alu_data,
   output logic                 o_alu_ready,
   input  logic                 i_load_issue,
   input  logic [ADDR_W-1:0]    i_load_reg,
   output logic                 o_load_issue_ready,
   input  logic                 i_load_rvalid,
   input  logic [DATA_W-1:0]    i_load_rdata,
   output logic                 o_write_control,
   output logic [ADDR_W-1:0]    o_write_reg,
   output logic [DATA_W-1:0]    o_write_data,
   output logic [REG_COUNT-1:0] o_pending_mask,
   output logic                 o_err
);

   logic [ADDR_W-1:0]                 w_head_reg;
   logic [DATA_W-1:0]                 w_head_data;
   logic                              w_head_has_data;
   logic [LOAD_DEPTH-1:0]             w_occupied;
   logic [LOAD_DEPTH-1:0][ADDR_W-1:0] w_entry_reg;
   logic                              w_fifo_full;
   logic                              w_fifo_empty;
   logic                              w_fill_miss;
   logic                              w_alloc;
   logic                              w_pop;
   logic [REG_COUNT-1:0]              w_mask;

   logic                              r_write_control;
   logic [ADDR_W-1:0]                 r_write_reg;
   logic [DATA_W-1:0]                 r_write_data;
   logic                              r_err;

   load_return_fifo #(
      .DEPTH  (LOAD_DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_alloc         (w_alloc),
      .i_alloc_reg     (i_load_reg),
      .i_rvalid        (i_load_rvalid),
      .i_rdata         (i_load_rdata),
      .i_pop           (w_pop),
      .o_head_reg      (w_head_reg),
      .o_head_data     (w_head_data),
      .o_head_has_data (w_head_has_data),
      .o_occupied      (w_occupied),
      .o_entry_reg     (w_entry_reg),
      .o_full          (w_fifo_full),
      .o_empty         (w_fifo_empty),
      .o_fill_miss     (w_fill_miss)
   );

   // Duplicate destinations simply OR together, so a bit stays set until its last load pops.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < LOAD_DEPTH; i++) begin
         if (w_occupied[i]) begin
            w_mask = w_mask | reg_onehot(w_entry_reg[i]);
         end
      end
   end

   assign o_load_issue_ready = ~w_fifo_full;
   assign w_alloc            = i_clk_enable & i_load_issue & ~w_fifo_full;
   assign w_pop              = i_clk_enable & w_head_has_data & ~w_fifo_empty;
   assign o_alu_ready        = i_clk_enable & i_alu_valid & ~w_head_has_data & ~w_mask[i_alu_reg];

   // A returned load always wins the port; writes to register 0 are consumed but suppressed.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_write_control <= 1'b0;
         r_write_reg     <= '0;
         r_write_data    <= '0;
         r_err           <= 1'b0;
      end else begin
         if (w_fill_miss) begin
            r_err <= 1'b1;
         end
         if (w_pop) begin
            r_write_control <= (w_head_reg != REG_ZERO);
            r_write_reg     <= w_head_reg;
            r_write_data    <= w_head_data;
         end else if (o_alu_ready) begin
            r_write_control <= (i_alu_reg != REG_ZERO);
            r_write_reg     <= i_alu_reg;
            r_write_data    <= i_alu_data;
         end else begin
            r_write_control <= 1'b0;
         end
      end
   end

   assign o_write_control = r_write_control;
   assign o_write_reg     = r_write_reg;
   assign o_write_data    = r_write_data;
   assign o_pending_mask  = w_mask;
   assign o_err           = r_err;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        clkEnable;
   logic        aluValid;
   logic [4:0]  aluReg;
   logic [31:0] aluData;
   logic        aluReady;
   logic        loadIssue;
   logic [4:0]  loadReg;
   logic        loadIssueReady;
   logic        loadRvalid;
   logic [31:0] loadRdata;
   logic        writeControl;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [31:0] pendingMask;
   logic        err;

   int errorCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter #(
      .LOAD_DEPTH (2),
      .DATA_W     (32),
      .ADDR_W     (5)
   ) dut (
      .i_clk              (clk),
      .i_reset            (reset),
      .i_clk_enable       (clkEnable),
      .i_alu_valid        (aluValid),
      .i_alu_reg          (aluReg),
      .i_alu_data         (aluData),
      .o_alu_ready        (aluReady),
      .i_load_issue       (loadIssue),
      .i_load_reg         (loadReg),
      .o_load_issue_ready (loadIssueReady),
      .i_load_rvalid      (loadRvalid),
      .i_load_rdata       (loadRdata),
      .o_write_control    (writeControl),
      .o_write_reg        (writeReg),
      .o_write_data       (writeData),
      .o_pending_mask     (pendingMask),
      .o_err              (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and settle before any combinational check.
   task automatic applyStimulus(input logic en, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic li, input logic [4:0] lr, input logic rv, input logic [31:0] rd);
      clkEnable  = en;
      aluValid   = av;
      aluReg     = ar;
      aluData    = ad;
      loadIssue  = li;
      loadReg    = lr;
      loadRvalid = rv;
      loadRdata  = rd;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkWrite(input string tag, input logic wc, input logic [4:0] wr, input logic [31:0] wd);
      checkOutput({tag, ".wc"}, {31'b0, writeControl}, {31'b0, wc});
      checkOutput({tag, ".reg"}, {27'b0, writeReg}, {27'b0, wr});
      checkOutput({tag, ".data"}, writeData, wd);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      checkOutput("rst.wc", {31'b0, writeControl}, 32'h0);
      checkOutput("rst.mask", pendingMask, 32'h0);
      checkOutput("rst.err", {31'b0, err}, 32'h0);
      checkOutput("rst.issueReady", {31'b0, loadIssueReady}, 32'h1);
      reset = 1'b0;

      // Reset mid-operation discards loads; a later return has nowhere to go.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 32'h0);
      tick();
      checkOutput("t1.maskBefore", pendingMask, 32'h30);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t1.maskAfter", pendingMask, 32'h0);
      checkOutput("t1.wc", {31'b0, writeControl}, 32'h0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hCAFE);
      tick();
      checkOutput("t1.err", {31'b0, err}, 32'h1);
      idle();
      tick();
      checkOutput("t1.errSticky", {31'b0, err}, 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t1.errCleared", {31'b0, err}, 32'h0);

      // ALU only.
      applyStimulus(1'b1, 1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 1'b0, 32'h0);
      checkOutput("t2.aluReady", {31'b0, aluReady}, 32'h1);
      tick();
      checkWrite("t2.write", 1'b1, 5'd8, 32'h1234);
      idle();
      tick();
      checkWrite("t2.hold", 1'b0, 5'd8, 32'h1234);

      // Loads drain in issue order.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 32'h0);
      tick();
      checkOutput("t3.mask30", pendingMask, 32'h30);
      checkOutput("t3.fullNotReady", {31'b0, loadIssueReady}, 32'h0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA);
      tick();
      checkOutput("t3.noWriteYet", {31'b0, writeControl}, 32'h0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hB);
      tick();
      checkWrite("t3.write4", 1'b1, 5'd4, 32'hA);
      checkOutput("t3.mask20", pendingMask, 32'h20);
      idle();
      tick();
      checkWrite("t3.write5", 1'b1, 5'd5, 32'hB);
      checkOutput("t3.mask0", pendingMask, 32'h0);

      // WAW hazard: ALU to $9 waits for the older load to $9.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 32'h0);
      tick();
      checkOutput("t4.mask", pendingMask, 32'h200);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 32'h0);
      checkOutput("t4.stall1", {31'b0, aluReady}, 32'h0);
      tick();
      checkOutput("t4.noWrite", {31'b0, writeControl}, 32'h0);
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b1, 32'h55);
      checkOutput("t4.stall2", {31'b0, aluReady}, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 32'h0);
      checkOutput("t4.stall3", {31'b0, aluReady}, 32'h0);
      tick();
      checkWrite("t4.loadWrite", 1'b1, 5'd9, 32'h55);
      checkOutput("t4.maskClear", pendingMask, 32'h0);
      checkOutput("t4.readyAfter", {31'b0, aluReady}, 32'h1);
      tick();
      checkWrite("t4.aluWrite", 1'b1, 5'd9, 32'h99);

      // Full FIFO blocks issue even while popping; load beats ALU.
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
      tick();
      checkOutput("t5.notReady", {31'b0, loadIssueReady}, 32'h0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 32'h22);
      tick();
      applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd6, 1'b0, 32'h0);
      checkOutput("t5.aluBlocked", {31'b0, aluReady}, 32'h0);
      checkOutput("t5.fullPopNotReady", {31'b0, loadIssueReady}, 32'h0);
      tick();
      checkWrite("t5.loadFirst", 1'b1, 5'd2, 32'h22);
      checkOutput("t5.maskOnly3", pendingMask, 32'h8);
      applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0, 32'h0);
      checkOutput("t5.aluReady", {31'b0, aluReady}, 32'h1);
      tick();
      checkWrite("t5.aluWrite", 1'b1, 5'd7, 32'h77);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h33);
      tick();
      idle();
      tick();
      checkWrite("t5.write3", 1'b1, 5'd3, 32'h33);
      checkOutput("t5.mask0", pendingMask, 32'h0);
      checkOutput("t5.err", {31'b0, err}, 32'h0);

      // Register 0 write is consumed but suppressed; freeze captures bus data without writing.
      applyStimulus(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b0, 32'h0);
      checkOutput("t6.reg0Ready", {31'b0, aluReady}, 32'h1);
      tick();
      checkOutput("t6.reg0NoWrite", {31'b0, writeControl}, 32'h0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 32'h0);
      tick();
      checkOutput("t6.mask", pendingMask, 32'h800);
      applyStimulus(1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 1'b1, 32'hBB);
      checkOutput("t6.frozenReady", {31'b0, aluReady}, 32'h0);
      tick();
      checkOutput("t6.frozenWc1", {31'b0, writeControl}, 32'h0);
      checkOutput("t6.frozenMask", pendingMask, 32'h800);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
      tick();
      checkOutput("t6.frozenWc2", {31'b0, writeControl}, 32'h0);
      idle();
      tick();
      checkWrite("t6.thawWrite", 1'b1, 5'd11, 32'hBB);
      checkOutput("t6.mask0", pendingMask, 32'h0);
      checkOutput("t6.err", {31'b0, err}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
